leb128_window: RTL and testbench
================================

// Module: leb128_window
// PURPOSE
//  Byte-stream front end for the combinational unpack_i32 decoder.
//  Buffers incoming LEB128 bytes and presents a zero-padded 5-byte window (w0..w4) once a
//  complete i32 frame is held. Retires the number of bytes the decoder reports (len).
//  Sits between the byte source (valid/ready) and unpack_i32.
// PARAMETERS
//  DEPTH  8  byte buffer capacity; legal range 5..16
// PORTS
//  clk         in   1  single clock, all state on rising edge
//  rst         in   1  synchronous, active-high reset
//  in_data     in   8  incoming LEB128 byte
//  in_valid    in   1  in_data valid
//  in_ready    out  1  buffer can accept a byte this cycle
//  w0..w4      out  8  window bytes 0..4 to unpack_i32 i0..i4; byte k = 8'h00 if k >= count
//  win_valid   out  1  window holds a complete frame
//  win_ready   in   1  downstream consumes the frame this cycle
//  consume_len in   3  bytes to retire (unpack_i32 len), legal 1..5
//  frame_len   out  3  frame length as seen by this block (1..5; 0 when !win_valid)
//  overlong    out  1  current frame has 5 bytes, all with bit7 set
//  err         out  1  sticky: illegal consume occurred; cleared only by rst
// BEHAVIOUR
//  - Reset: count=0, buffer=0, in_ready=0 during rst then 1, win_valid=0, w0..w4=0,
//    frame_len=0, overlong=0, err=0. Reset mid-frame discards all buffered bytes.
//  - Storage: buf[0..DEPTH-1] shift register plus count (clog2(DEPTH+1) bits); buf[0] oldest.
//  - in_ready = (count < DEPTH). Registered state only, no combinational path from
//    win_ready/consume_len.
//  - push = in_valid & in_ready. pop = win_valid & win_ready.
//  - win_valid (combinational from state):
//    set when some k < min(count,5) has buf[k][7]==0, or when count >= 5.
//  - frame_len:
//    index of first byte with bit7==0, plus 1, among the first min(count,5) bytes.
//    Equals 5 if none is found and count >= 5.
//  - overlong = win_valid & (count>=5) & buf[0..4] all have bit7 set.
//    Window is still presented; the decoder truncates.
//  - Legal pop: 1 <= consume_len <= min(frame_len,5).
//    Effect: buffer shifts down by consume_len and count -= consume_len.
//  - Illegal pop (consume_len==0, >5, or >frame_len): no bytes retired, err <= 1.
//    A push in the same cycle still occurs.
//  - Simultaneous push+pop:
//    shift first, then write in_data at index (count - consume_len).
//    New count = count - consume_len + 1. No lost or duplicated bytes.
//  - Latency: a byte pushed in cycle N is visible in the window in cycle N+1.
//    A terminating byte makes win_valid high in cycle N+1.
//  - Throughput: 1 byte/cycle input. One frame retired per cycle while frames are buffered.
//  - Full: count==DEPTH drops in_ready. A pop in that cycle does not raise in_ready
//    until the next cycle.
//  - Window outputs are combinational from buf/count. Bytes at or beyond count read 8'h00.
// STRUCTURE
//  - Shared package leb128_pkg:
//    - LEB_CONT_BIT=7
//    - LEB_I32_MAX_BYTES=5
//    - byte_t typedef
//    - function leb_frame_len(window, count) also used by leb128_window_u32 later
//  - Single sub-module leb128_term_scan:
//    - combinational; inputs: 5 bytes + count
//    - outputs: frame_len, found, overlong
//  - Top holds the shift buffer, count and err.
//  - unpack_i32 is NOT instantiated here. The integration wrapper ties w0..w4 -> i0..i4
//    and len -> consume_len.
// TESTING
//  - Bench instantiates leb128_window + unpack_i32 with len looped to consume_len, win_ready=1.
//  1 Push 9b,f1,59 -> after 3rd byte:
//    - w=9b f1 59 00 00, win_valid=1, frame_len=3
//    - decoder o=-624485 (32'hFFF6_789B)
//    - pop retires 3 bytes; count=0
//  2 Push 00 then 7f back-to-back -> two frames, each frame_len=1
//    - o=0 then o=-1
//    - win_valid high in consecutive cycles; err=0
//  3 win_ready=0, push 8 bytes 80 -> in_ready=0 after 8th
//    - win_valid=1, overlong=1, frame_len=5
//    - a 9th in_valid byte is not accepted
//  4 Hold count=3 frames 01,02,03 and pop (len=1) while pushing 04 in the same cycle
//    - count stays 3; window becomes 02 03 04 00 00
//  5 Force consume_len=0 on a pop -> err=1 sticky, count unchanged
//    - then rst -> err=0, count=0, win_valid=0
//  6 Assert rst after 2 of 3 bytes of 9b f1 59
//    - window all 00, win_valid=0
//    - subsequent 2a decodes o=42, len=1

Source files
------------

// File: rtl/leb128_pkg.sv
`default_nettype none
// leb128_pkg - shared constants, byte type and frame-length helpers for LEB128 byte front ends.
// Rev 1.0
package leb128_pkg;

  localparam int LEB_CONT_BIT      = 7;
  localparam int LEB_I32_MAX_BYTES = 5;

  typedef logic [7:0] byte_t;

  // Continuation flags of the five window bytes, byte 0 in bit 0.
  function automatic logic [4:0] leb_cont_bits(input logic [39:0] window);
    return {window[4*8+LEB_CONT_BIT], window[3*8+LEB_CONT_BIT], window[2*8+LEB_CONT_BIT],
            window[1*8+LEB_CONT_BIT], window[0*8+LEB_CONT_BIT]};
  endfunction

  // One bit per window byte that is actually held.
  function automatic logic [4:0] leb_in_range(input logic [4:0] count);
    return {count > 5'd4, count > 5'd3, count > 5'd2, count > 5'd1, count > 5'd0};
  endfunction

  // First terminator position plus one; 5 when five bytes are held without a terminator.
  function automatic logic [2:0] leb_frame_len(input logic [39:0] window, input logic [4:0] count);
    logic [4:0] term;
    logic [2:0] len;
    term = ~leb_cont_bits(window) & leb_in_range(count);
    if (term[0])      len = 3'd1;
    else if (term[1]) len = 3'd2;
    else if (term[2]) len = 3'd3;
    else if (term[3]) len = 3'd4;
    else if (term[4]) len = 3'd5;
    else if (count >= 5'(LEB_I32_MAX_BYTES)) len = 3'(LEB_I32_MAX_BYTES);
    else len = 3'd0;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/leb128_term_scan.sv
`default_nettype none
// leb128_term_scan - combinational terminator search over the first five buffered bytes.
// Rev 1.0
module leb128_term_scan
  import leb128_pkg::*;
(
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [7:0] b3,
  input  logic [7:0] b4,
  input  logic [4:0] count,
  output logic [2:0] frame_len,
  output logic       found,
  output logic       overlong
);

  logic [39:0] window;
  logic [4:0]  cont;
  logic        five_held;

  assign window    = {b4, b3, b2, b1, b0};
  assign cont      = leb_cont_bits(window);
  assign five_held = (count >= 5'(LEB_I32_MAX_BYTES));

  assign found     = |(~cont & leb_in_range(count));
  assign frame_len = leb_frame_len(window, count);
  assign overlong  = five_held & (&cont);

endmodule
`default_nettype wire

// File: rtl/leb128_window.sv
`default_nettype none
// leb128_window - buffers LEB128 bytes and presents a zero-padded 5-byte window holding one i32 frame.
// Rev 1.0
module leb128_window
  import leb128_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] w0,
  output logic [7:0] w1,
  output logic [7:0] w2,
  output logic [7:0] w3,
  output logic [7:0] w4,
  output logic       win_valid,
  input  logic       win_ready,
  input  logic [2:0] consume_len,
  output logic [2:0] frame_len,
  output logic       overlong,
  output logic       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = DEPTH * 8;

  // Byte 0 (oldest) lives in bits [7:0]; bytes at or beyond count are always zero.
  logic [BW-1:0] buf_q;
  logic [BW-1:0] buf_shifted;
  logic [BW-1:0] buf_next;
  logic [CW-1:0] count;
  logic [CW-1:0] retire;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] count_next;

  byte_t         win [5];
  logic          found;
  logic          push;
  logic          pop;
  logic          legal;

  for (genvar k = 0; k < 5; k++) begin : g_win
    assign win[k] = (count > CW'(k)) ? buf_q[k*8 +: 8] : 8'h00;
  end

  assign w0 = win[0];
  assign w1 = win[1];
  assign w2 = win[2];
  assign w3 = win[3];
  assign w4 = win[4];

  leb128_term_scan u_scan (
    .b0        (win[0]),
    .b1        (win[1]),
    .b2        (win[2]),
    .b3        (win[3]),
    .b4        (win[4]),
    .count     (5'(count)),
    .frame_len (frame_len),
    .found     (found),
    .overlong  (overlong)
  );

  assign win_valid = found | (count >= CW'(LEB_I32_MAX_BYTES));
  assign in_ready  = ~rst & (count < CW'(DEPTH));

  assign push  = in_valid & in_ready;
  assign pop   = win_valid & win_ready;
  assign legal = (consume_len != 3'd0) && (consume_len <= frame_len);

  // Shift out the retired bytes first, then land the new byte just above the survivors.
  assign retire      = (pop && legal) ? CW'(consume_len) : '0;
  assign wr_idx      = count - retire;
  assign buf_shifted = buf_q >> {retire, 3'b000};
  assign buf_next    = push ? (buf_shifted | (BW'(in_data) << {wr_idx, 3'b000})) : buf_shifted;
  assign count_next  = wr_idx + CW'(push);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      buf_q <= buf_next;
      count <= count_next;
      if (pop && !legal) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leb128_window.sv
`default_nettype none
// tb_leb128_window - directed scenarios plus randomized frame stream scored against an LEB128 model.
module tb_leb128_window;

  localparam int DEPTH = 8;
  localparam int NFRAMES = 150;
  localparam int MAX_CYC = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] w0, w1, w2, w3, w4;
  logic       win_valid;
  logic       win_ready = 1'b0;
  logic [2:0] consume_len = 3'd1;
  logic [2:0] frame_len;
  logic       overlong;
  logic       err;
  logic [39:0] win_w;

  always #5 clk = ~clk;

  leb128_window #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .w0          (w0),
    .w1          (w1),
    .w2          (w2),
    .w3          (w3),
    .w4          (w4),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .consume_len (consume_len),
    .frame_len   (frame_len),
    .overlong    (overlong),
    .err         (err)
  );

  assign win_w = {w4, w3, w2, w1, w0};

  typedef struct {
    logic [39:0] bytes;
    int          len;
    logic        ov;
    logic [31:0] val;
  } frame_t;

  frame_t     sb_q[$];
  int         len_q[$];
  logic [7:0] byte_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         sb_on = 1'b0;

  // Signed LEB128 i32 decode of the first len bytes, truncated to 32 bits.
  function automatic logic [31:0] dec(input logic [39:0] w, input int len);
    logic [63:0] acc;
    acc = 64'd0;
    if (len < 1) return 32'd0;
    for (int k = 0; k < len; k++) acc = acc | (64'(w[k*8 +: 7]) << (7 * k));
    if (len < 5 && w[(len-1)*8 + 6]) acc = acc | (~64'd0 << (7 * len));
    return acc[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic [2:0] l);
    in_valid = v;
    in_data = d;
    win_ready = r;
    consume_len = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    win_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    win_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_window", win_w, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_overlong", overlong, 0);
    chk("rst_err", err, 0);
  endtask

  // Monitor: every handshaken frame is compared with the oldest expected frame.
  initial begin
    frame_t      e;
    logic [39:0] mask;
    forever begin
      @(negedge clk);
      if (sb_on && win_valid && win_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_pop actual=frame expected=none");
        end else begin
          e = sb_q.pop_front();
          mask = (40'd1 << (8 * e.len)) - 40'd1;
          chk("sb_frame_len", frame_len, e.len);
          chk("sb_overlong", overlong, e.ov);
          chk("sb_window", win_w & mask, e.bytes);
          chk("sb_value", dec(win_w, e.len), e.val);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t     f;
    logic [7:0] b;
    int         v;
    int         n;
    bit         done;
    bit         pushed;
    bit         popped;
    int         cyc;

    do_reset();

    // Three-byte frame 9b f1 59
    step(1'b1, 8'h9b, 1'b0, 3'd3);
    step(1'b1, 8'hf1, 1'b0, 3'd3);
    chk("t1_partial_valid", win_valid, 0);
    step(1'b1, 8'h59, 1'b0, 3'd3);
    chk("t1_window", win_w, 40'h00_00_59_f1_9b);
    chk("t1_valid", win_valid, 1);
    chk("t1_len", frame_len, 3);
    chk("t1_value", dec(win_w, 3), 32'hFFF6_789B);
    step(1'b0, 8'h00, 1'b1, 3'd3);
    chk("t1_empty_valid", win_valid, 0);
    chk("t1_empty_window", win_w, 0);

    // Back-to-back single-byte frames
    step(1'b1, 8'h00, 1'b0, 3'd1);
    chk("t2_f0_valid", win_valid, 1);
    chk("t2_f0_len", frame_len, 1);
    chk("t2_f0_value", dec(win_w, 1), 32'h0);
    step(1'b1, 8'h7f, 1'b1, 3'd1);
    chk("t2_f1_valid", win_valid, 1);
    chk("t2_f1_len", frame_len, 1);
    chk("t2_f1_window", win_w, 40'h7f);
    chk("t2_f1_value", dec(win_w, 1), 32'hFFFF_FFFF);
    step(1'b0, 8'h00, 1'b1, 3'd1);
    chk("t2_valid_after", win_valid, 0);
    chk("t2_err", err, 0);

    // Fill with continuation bytes
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h80, 1'b0, 3'd1);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_valid", win_valid, 1);
    chk("t3_overlong", overlong, 1);
    chk("t3_len", frame_len, 5);
    in_valid = 1'b1;
    in_data = 8'h01;
    win_ready = 1'b1;
    consume_len = 3'd5;
    #1;
    chk("t3_no_comb_ready", in_ready, 0);
    step(1'b1, 8'h01, 1'b1, 3'd5);
    chk("t3_after_pop_window", win_w, 40'h00_00_80_80_80);
    chk("t3_after_pop_ready", in_ready, 1);
    chk("t3_after_pop_valid", win_valid, 0);
    do_reset();

    // Pop and push in the same cycle
    step(1'b1, 8'h01, 1'b0, 3'd1);
    step(1'b1, 8'h02, 1'b0, 3'd1);
    step(1'b1, 8'h03, 1'b0, 3'd1);
    step(1'b1, 8'h04, 1'b1, 3'd1);
    chk("t4_window", win_w, 40'h00_04_03_02);
    chk("t4_len", frame_len, 1);
    do_reset();

    // Illegal consume lengths
    step(1'b1, 8'h01, 1'b0, 3'd1);
    step(1'b1, 8'h05, 1'b1, 3'd0);
    chk("t5_err", err, 1);
    chk("t5_window", win_w, 40'h05_01);
    step(1'b0, 8'h00, 1'b0, 3'd1);
    chk("t5_err_sticky", err, 1);
    do_reset();
    step(1'b1, 8'h01, 1'b0, 3'd1);
    step(1'b0, 8'h00, 1'b1, 3'd3);
    chk("t5_over_err", err, 1);
    chk("t5_over_window", win_w, 40'h01);
    do_reset();

    // Reset mid-frame
    step(1'b1, 8'h9b, 1'b0, 3'd1);
    step(1'b1, 8'hf1, 1'b0, 3'd1);
    do_reset();
    step(1'b1, 8'h2a, 1'b0, 3'd1);
    chk("t6_len", frame_len, 1);
    chk("t6_value", dec(win_w, 1), 32'd42);
    step(1'b0, 8'h00, 1'b1, 3'd1);
    chk("t6_valid_after", win_valid, 0);

    // Randomized frame stream
    for (int i = 0; i < NFRAMES; i++) begin
      f.bytes = 40'd0;
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 5; k++) begin
          b = 8'($urandom) | 8'h80;
          f.bytes[k*8 +: 8] = b;
          byte_q.push_back(b);
        end
        f.len = 5;
        f.ov = 1'b1;
        f.val = dec(f.bytes, 5);
      end else begin
        v = int'($urandom) >>> $urandom_range(0, 31);
        f.val = v;
        n = 0;
        done = 1'b0;
        while (!done) begin
          b = 8'(v & 32'h7f);
          v = v >>> 7;
          done = (v == 0 && !b[6]) || (v == -1 && b[6]);
          if (!done) b[7] = 1'b1;
          f.bytes[n*8 +: 8] = b;
          byte_q.push_back(b);
          n++;
        end
        f.len = n;
        f.ov = 1'b0;
      end
      sb_q.push_back(f);
      len_q.push_back(f.len);
    end

    sb_on = 1'b1;
    cyc = 0;
    while ((byte_q.size() > 0 || len_q.size() > 0) && cyc < MAX_CYC) begin
      in_valid = (byte_q.size() > 0) && ($urandom_range(0, 9) < 7);
      in_data = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
      win_ready = ($urandom_range(0, 9) < 6);
      consume_len = (len_q.size() > 0) ? 3'(len_q[0]) : 3'd1;
      @(negedge clk);
      pushed = in_valid && in_ready;
      popped = win_valid && win_ready;
      @(posedge clk);
      #1;
      if (pushed) void'(byte_q.pop_front());
      if (popped && len_q.size() > 0) void'(len_q.pop_front());
      cyc++;
    end
    in_valid = 1'b0;
    win_ready = 1'b0;
    if (cyc >= MAX_CYC) begin
      checks++;
      failures++;
      $display("FAIL rand_drain_timeout actual=%0d_left expected=0", len_q.size());
    end
    @(negedge clk);
    chk("rand_sb_empty", sb_q.size(), 0);
    chk("rand_err", err, 0);
    chk("rand_final_valid", win_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
